// File: rtl/rom_port_arbiter.sv
`timescale 1ns/1ps
// rom_port_arbiter: shares one 32-bit memory read port among
// tile, sprite, theme and 68k ROM clients (fixed priority).
module rom_port_arbiter #(
  parameter logic [23:0] TILES_BASE = 24'h000000,
  parameter logic [23:0] SPR_BASE   = 24'h040000,
  parameter logic [23:0] THEME_BASE = 24'h0C0000,
  parameter logic [23:0] M68K_BASE  = 24'h100000
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        tiles_rom_req,
  input  logic [17:0] tiles_rom_addr,
  output logic [31:0] tiles_rom_dout,
  input  logic        spr_rom_req,
  input  logic [18:0] spr_rom_addr,
  output logic [31:0] spr_rom_dout,
  input  logic        theme_rom_req,
  input  logic [17:0] theme_rom_addr,
  output logic [31:0] theme_rom_dout,
  input  logic        m68k_rom_req,
  input  logic [17:0] m68k_rom_addr,
  output logic [15:0] m68k_rom_dout,
  output logic        sdram_dtack,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_dout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam int TI = 0;
  localparam int SP = 1;
  localparam int TH = 2;
  localparam int MK = 3;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  w_req;
  logic [3:0]  r_pend;
  logic [3:0]  w_pick;
  logic [3:0]  w_clr;
  logic        w_grant;
  logic        w_done;
  logic [23:0] w_addr;
  logic        w_m68k_busy;

  logic [17:0] r_tiles_addr;
  logic [18:0] r_spr_addr;
  logic [17:0] r_theme_addr;
  logic [17:0] r_m68k_addr;

  logic [3:0]  r_sel;
  logic        r_m68k_hi;

  logic        r_mem_req;
  logic [23:0] r_mem_addr;

  logic [31:0] r_tiles_dout;
  logic [31:0] r_spr_dout;
  logic [31:0] r_theme_dout;
  logic [15:0] r_m68k_dout;

  assign w_req = {m68k_rom_req, theme_rom_req,
                  spr_rom_req, tiles_rom_req};

  // Fixed priority pick: tiles, then sprites, theme, 68k.
  always_comb begin
    w_pick = 4'b0000;
    if (r_pend[TI])
      w_pick = 4'b0001;
    else if (r_pend[SP])
      w_pick = 4'b0010;
    else if (r_pend[TH])
      w_pick = 4'b0100;
    else if (r_pend[MK])
      w_pick = 4'b1000;
  end

  // Memory word address of the winning source.
  // 68k addresses are 16-bit words, two per memory word.
  always_comb begin
    w_addr = 24'h000000;
    unique case (1'b1)
      w_pick[TI]:
        w_addr = TILES_BASE + {6'b0, r_tiles_addr};
      w_pick[SP]:
        w_addr = SPR_BASE + {5'b0, r_spr_addr};
      w_pick[TH]:
        w_addr = THEME_BASE + {6'b0, r_theme_addr};
      w_pick[MK]:
        w_addr = M68K_BASE + {7'b0, r_m68k_addr[17:1]};
      default:
        w_addr = 24'h000000;
    endcase
  end

  // Next state plus grant/completion strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_valid) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign w_clr = w_grant ? w_pick : 4'b0000;

  // FSM state register.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Pending flags: a new pulse wins over the grant clear,
  // so a re-request of the winner is served again.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET)
      r_pend <= 4'b0000;
    else
      r_pend <= (r_pend & ~w_clr) | w_req;
  end

  // Address latches; a later pulse overwrites an unserved one.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      r_tiles_addr <= '0;
      r_spr_addr   <= '0;
      r_theme_addr <= '0;
      r_m68k_addr  <= '0;
    end else begin
      if (w_req[TI])
        r_tiles_addr <= tiles_rom_addr;
      if (w_req[SP])
        r_spr_addr <= spr_rom_addr;
      if (w_req[TH])
        r_theme_addr <= theme_rom_addr;
      if (w_req[MK])
        r_m68k_addr <= m68k_rom_addr;
    end
  end

  // Remember who owns the read in flight and which
  // 16-bit half the 68k wants, since latches may move.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      r_sel     <= 4'b0000;
      r_m68k_hi <= 1'b0;
    end else if (w_grant) begin
      r_sel     <= w_pick;
      r_m68k_hi <= r_m68k_addr[0];
    end
  end

  // Memory request port, held stable until mem_valid.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= 24'h000000;
    end else if (w_grant) begin
      r_mem_req  <= 1'b1;
      r_mem_addr <= w_addr;
    end else if (w_done) begin
      r_mem_req  <= 1'b0;
    end
  end

  // Return data to the owning client and hold it there.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      r_tiles_dout <= 32'h0;
      r_spr_dout   <= 32'h0;
      r_theme_dout <= 32'h0;
      r_m68k_dout  <= 16'h0;
    end else if (w_done) begin
      unique case (1'b1)
        r_sel[TI]: r_tiles_dout <= mem_dout;
        r_sel[SP]: r_spr_dout   <= mem_dout;
        r_sel[TH]: r_theme_dout <= mem_dout;
        r_sel[MK]: r_m68k_dout  <= r_m68k_hi ?
                                   mem_dout[31:16] :
                                   mem_dout[15:0];
        default: ;
      endcase
    end
  end

  assign w_m68k_busy = (r_state == S_BUSY) && r_sel[MK];

  assign sdram_dtack = ~(nRESET & (m68k_rom_req |
                                   r_pend[MK] |
                                   w_m68k_busy));

  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;
  assign tiles_rom_dout = r_tiles_dout;
  assign spr_rom_dout   = r_spr_dout;
  assign theme_rom_dout = r_theme_dout;
  assign m68k_rom_dout  = r_m68k_dout;

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter: TILES_BASE, 24'h000000, word base of tile ROM region in 32-bit memory.
REQ-002 Parameter: SPR_BASE, 24'h040000, word base of sprite ROM region.
REQ-003 Parameter: THEME_BASE, 24'h0C0000, word base of theme/sample ROM region.
REQ-004 Parameter: M68K_BASE, 24'h100000, word base of 68k program ROM region.
REQ-005 Ports, clock and reset first:
- clk_sys  in  1  system clock, 96 MHz.
- nRESET  in  1  reset, asynchronous, active-low.
- tiles_rom_req  in  1  one-cycle request pulse.
- tiles_rom_addr  in  18  tile ROM 32-bit word address.
- tiles_rom_dout  out  32  tile read data.
- spr_rom_req  in  1  one-cycle request pulse.
- spr_rom_addr  in  19  sprite ROM 32-bit word address.
- spr_rom_dout  out  32  sprite read data.
- theme_rom_req  in  1  one-cycle request pulse.
- theme_rom_addr  in  18  theme ROM 32-bit word address.
- theme_rom_dout  out  32  theme read data.
- m68k_rom_req  in  1  one-cycle request pulse.
- m68k_rom_addr  in  18  68k ROM 16-bit word address.
- m68k_rom_dout  out  16  68k read data.
- sdram_dtack  out  1  high = 68k may complete cycle.
- mem_req  out  1  memory read request, level.
- mem_addr  out  24  memory 32-bit word address.
- mem_valid  in  1  one-cycle pulse, mem_dout valid.
- mem_dout  in  32  memory read data.

Function
REQ-006 Each source SHALL own a pending flag and address latch; a request pulse sets the flag and captures the address on that clk_sys edge.
REQ-007 A request to an already-pending source SHALL overwrite the latched address; one memory read serves it.
REQ-008 FSM states SHALL be IDLE and BUSY only.
REQ-009 IDLE: if any flag set, select highest-priority pending source (tiles > spr > theme > m68k), drive mem_addr, assert mem_req, clear that flag, go BUSY on the next edge.
REQ-010 BUSY: mem_req and mem_addr SHALL remain stable until the cycle mem_valid is sampled high; then mem_req deasserts, data is written to the selected source's output, FSM returns to IDLE.
REQ-011 Minimum request spacing SHALL be one IDLE cycle between consecutive mem_req assertions.
REQ-012 A request pulse for the source currently in BUSY SHALL set its flag again and be served as a new read.
REQ-013 mem_valid while IDLE SHALL be ignored.
REQ-014 mem_addr SHALL be base + zero-extended address for tiles, spr, theme; M68K_BASE + m68k_rom_addr[17:1] for m68k.
REQ-015 m68k_rom_dout SHALL take mem_dout[15:0] when latched m68k_rom_addr[0]=0, mem_dout[31:16] when 1.
REQ-016 Data outputs SHALL be registered and hold value until the next completion for that source.
REQ-017 sdram_dtack SHALL be low combinationally in the cycle m68k_rom_req is high, and while the m68k flag is set or m68k is in BUSY; it SHALL return high the cycle after m68k data is latched.
REQ-018 Address sums SHALL be 24-bit, wrap modulo 2^24, no overflow detection.

Reset
REQ-019 nRESET low SHALL immediately clear all flags, FSM to IDLE, mem_req=0, mem_addr=0, all data outputs=0, sdram_dtack=1.
REQ-020 Reset asserted during BUSY SHALL abandon the read; a later mem_valid SHALL be ignored.
REQ-021 Request pulses while nRESET low SHALL be discarded.

Verification
REQ-022 Single m68k req addr 18'h00003, memory returns 32'hAABBCCDD after 5 cycles -> mem_addr=24'h100001, sdram_dtack low from req cycle, m68k_rom_dout=16'hAABB, dtack high next cycle.
REQ-023 tiles, spr, theme, m68k pulsed same cycle -> mem_req order tiles, spr, theme, m68k; each output holds its own returned word.
REQ-024 Two spr pulses (addr 1 then 2) before grant -> one read at SPR_BASE+2.
REQ-025 spr pulse during its own BUSY -> second read issued after first completes.
REQ-026 nRESET low mid-BUSY, then mem_valid pulse -> mem_req=0 immediately, outputs stay 0, sdram_dtack=1.
REQ-027 mem_valid pulse in IDLE with no pending -> no output change.
